sm4_round_engine: RTL and testbench

- Iterative SM4 engine; the stage directly upstream of the encrypt/decrypt T transform, which it instantiates.
- Each round it forms the T input X1^X2^X3^rk and consumes the T result into the 128-bit state shift register.
- Owns key expansion: it derives 32 round keys from a 128-bit master key into an internal register file, then runs 32-round encrypt or decrypt with valid/ready handshakes.

---
 rtl/sm4_round_engine.sv | 216 +++++++++++++++++++++
 tb/tb_sm4_round_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_round_engine.sv
// sm4_round_engine: iterative SM4 block cipher core.
//
// Expands a 128-bit master key into 32 round keys (one per cycle), then runs
// 32-round encrypt or decrypt on 128-bit blocks, one round per cycle, with
// valid/ready handshakes on key, input block and result.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   key_valid   master key offered          key_ready  engine accepts a key
//   key_in      MK0..MK3, MK0 in [127:96]
//   in_valid    data block offered          in_ready   engine accepts a block
//   in_decrypt  1 = decrypt, 0 = encrypt, sampled with the block
//   in_data     X0..X3, X0 in [127:96]
//   out_valid   result available            out_ready  downstream accepts it
//   out_data    (X35,X34,X33,X32), X35 in [127:96]
//   key_loaded  round-key file holds a valid expanded key
//
// Also contains the SM4 S-box and the encrypt/decrypt T transform used by
// the round datapath.

// SM4 S-box: one byte in, one byte out, purely combinational.
module sm4_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign dout = SBOX[din];
endmodule

// SM4 encrypt/decrypt T transform: tau (four S-boxes) followed by
// L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
module sm4_t (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    logic [31:0] b;

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        sm4_sbox u_sbox (.din(din[8*j +: 8]), .dout(b[8*j +: 8]));
    end

    assign dout = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                    ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
endmodule

module sm4_round_engine #(
    parameter logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         key_loaded
);
    typedef enum logic [2:0] {IDLE, KEYEXP, READY, CRYPT, DONE} state_t;

    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] key_reg;
    logic [127:0] x_reg;
    logic         decrypt;
    logic         crypt_last;
    logic [31:0]  rkfile [0:31];

    // Key schedule: CK bytes are ((4i+j)*7) mod 256, so 8-bit arithmetic
    // gives the modulo for free.
    logic [7:0]  ck_base;
    logic [31:0] ck;
    logic [31:0] key_mix;
    logic [31:0] key_tau;
    logic [31:0] rk_new;

    assign ck_base = {1'b0, cnt, 2'b00};
    assign ck = {ck_base * 8'd7, (ck_base + 8'd1) * 8'd7,
                 (ck_base + 8'd2) * 8'd7, (ck_base + 8'd3) * 8'd7};
    assign key_mix = key_reg[95:64] ^ key_reg[63:32] ^ key_reg[31:0] ^ ck;

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        sm4_sbox u_key_sbox (.din(key_mix[8*j +: 8]), .dout(key_tau[8*j +: 8]));
    end

    assign rk_new = key_reg[127:96] ^ key_tau
                  ^ {key_tau[18:0], key_tau[31:19]} ^ {key_tau[8:0], key_tau[31:9]};

    // Round datapath: decryption reuses the same round with keys in reverse order.
    logic [4:0]  rk_index;
    logic [31:0] rk_sel;
    logic [31:0] t_in;
    logic [31:0] t_out;
    logic [31:0] x_new;

    assign rk_index = decrypt ? (5'd31 - cnt) : cnt;
    assign rk_sel   = rkfile[rk_index];
    assign t_in     = x_reg[95:64] ^ x_reg[63:32] ^ x_reg[31:0] ^ rk_sel;

    sm4_t u_t (.din(t_in), .dout(t_out));

    assign x_new = x_reg[127:96] ^ t_out;

    // The round-key file has no reset; it is only meaningful while key_loaded.
    always_ff @(posedge clk) begin
        if (state == KEYEXP) begin
            rkfile[cnt] <= rk_new;
        end
    end

    // Control FSM. crypt_last adds the output register stage after round 31,
    // so the counter itself only ever spans the 32 rounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            key_reg    <= '0;
            x_reg      <= '0;
            decrypt    <= 1'b0;
            crypt_last <= 1'b0;
            key_loaded <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            key_ready  <= 1'b1;
            in_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_reg   <= key_in ^ FK;
                        cnt       <= 5'd0;
                        key_ready <= 1'b0;
                        state     <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key_reg <= {key_reg[95:0], rk_new};
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        key_loaded <= 1'b1;
                        key_ready  <= 1'b1;
                        in_ready   <= 1'b1;
                        state      <= READY;
                    end
                end
                READY: begin
                    // A new key wins over a block offered in the same cycle.
                    if (key_valid) begin
                        key_reg    <= key_in ^ FK;
                        cnt        <= 5'd0;
                        key_loaded <= 1'b0;
                        key_ready  <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= KEYEXP;
                    end else if (in_valid) begin
                        x_reg      <= in_data;
                        decrypt    <= in_decrypt;
                        cnt        <= 5'd0;
                        crypt_last <= 1'b0;
                        key_ready  <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= CRYPT;
                    end
                end
                CRYPT: begin
                    if (crypt_last) begin
                        out_data   <= {x_reg[31:0], x_reg[63:32], x_reg[95:64], x_reg[127:96]};
                        out_valid  <= 1'b1;
                        crypt_last <= 1'b0;
                        state      <= DONE;
                    end else begin
                        x_reg <= {x_reg[95:0], x_new};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            crypt_last <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        key_ready <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= READY;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm4_round_engine.sv
// tb_sm4_round_engine: self-checking bench for sm4_round_engine.
// Known-answer vectors plus randomized keys/blocks compared against an
// array-based SM4 reference model; also covers backpressure, key/block
// collision and mid-operation reset.
module tb_sm4_round_engine;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_decrypt = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         key_loaded;

    int checks = 0;
    int passed = 0;

    localparam logic [127:0] KEY_KAT   = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] PLAIN_KAT = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CIPH_KAT  = 128'h681EDF34D206965E86B3E94F536E4246;

    sm4_round_engine dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_loaded(key_loaded)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] sbox_tbl [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [127:0] fk_model = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    logic [31:0]  model_rk [32];

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] v);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_tbl[v[8*j +: 8]];
        return r;
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk_model[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            ck = 0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            model_rk[i] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            k[i+4] = model_rk[i];
        end
    endtask

    function automatic logic [127:0] model_crypt(input logic [127:0] data, input logic dec);
        logic [31:0] x [36];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) x[i] = data[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? model_rk[31-i] : model_rk[i]));
            x[i+4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- checking / driving ----------------
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic kv, input logic iv, input logic dec,
                                 input logic [127:0] key, input logic [127:0] data);
        key_valid  = kv;
        in_valid   = iv;
        in_decrypt = dec;
        key_in     = key;
        in_data    = data;
    endtask

    task automatic load_key(input logic [127:0] mk, input string tag);
        int lat;
        @(negedge clk);
        checkOutput({tag, " key_ready"}, 128'(key_ready), 128'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, mk, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput({tag, " key_loaded cleared"}, 128'(key_loaded), 128'd0);
        lat = 0;
        while (!key_loaded && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " keyexp latency"}, 128'(lat), 128'd32);
        model_expand(mk);
    endtask

    task automatic run_block(input logic [127:0] data, input logic dec,
                             input logic [127:0] expected, input string tag);
        int lat;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, 128'(in_ready), 128'd1);
        applyStimulus(1'b0, 1'b1, dec, '0, data);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 128'(lat), 128'd33);
        checkOutput({tag, " out_data"}, out_data, expected);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " out_valid cleared"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] rkey;
        logic [127:0] rdata;
        logic [127:0] rexp;
        logic         rdec;
        int           lat;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset key_ready", 128'(key_ready), 128'd1);
        checkOutput("reset in_ready", 128'(in_ready), 128'd0);
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset key_loaded", 128'(key_loaded), 128'd0);
        checkOutput("reset out_data", out_data, 128'd0);
        rst = 1'b0;

        // Known-answer key expansion and encrypt/decrypt
        load_key(KEY_KAT, "kat");
        checkOutput("kat rk0", 128'(dut.rkfile[0]), 128'h0F12186F9);
        checkOutput("kat rk31", 128'(dut.rkfile[31]), 128'h09124A012);
        checkOutput("model rk0", 128'(model_rk[0]), 128'h0F12186F9);
        for (int i = 0; i < 32; i++) checkOutput($sformatf("rk%0d vs model", i), 128'(dut.rkfile[i]), 128'(model_rk[i]));
        run_block(PLAIN_KAT, 1'b0, CIPH_KAT, "kat enc");
        run_block(CIPH_KAT, 1'b1, PLAIN_KAT, "kat dec");

        // Backpressure: result held, key/block offers ignored while DONE
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, PLAIN_KAT);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp latency", 128'(lat), 128'd33);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i[0], ~i[0], 1'b1, {$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
            checkOutput("bp out_data stable", out_data, CIPH_KAT);
            checkOutput("bp out_valid held", 128'(out_valid), 128'd1);
            checkOutput("bp in_ready low", 128'(in_ready), 128'd0);
            checkOutput("bp key_ready low", 128'(key_ready), 128'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp back to ready", 128'(in_ready), 128'd1);
        checkOutput("bp key kept", 128'(key_loaded), 128'd1);
        checkOutput("bp out_data kept", out_data, CIPH_KAT);
        run_block(PLAIN_KAT, 1'b0, CIPH_KAT, "bp key unchanged");

        // Simultaneous key and block in READY: key wins, block dropped
        rkey  = {$urandom, $urandom, $urandom, $urandom};
        rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, rkey, rdata);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("coll in_ready low", 128'(in_ready), 128'd0);
        checkOutput("coll key_loaded low", 128'(key_loaded), 128'd0);
        lat = 0;
        while (!key_loaded && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("coll keyexp latency", 128'(lat), 128'd32);
        checkOutput("coll no result", 128'(out_valid), 128'd0);
        model_expand(rkey);
        run_block(rdata, 1'b0, model_crypt(rdata, 1'b0), "coll enc");

        // Randomized keys and blocks against the model
        for (int k = 0; k < 4; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            load_key(rkey, $sformatf("rnd key%0d", k));
            for (int b = 0; b < 3; b++) begin
                rdata = {$urandom, $urandom, $urandom, $urandom};
                rdec  = 1'($urandom_range(0, 1));
                rexp  = model_crypt(rdata, rdec);
                run_block(rdata, rdec, rexp, $sformatf("rnd k%0d b%0d", k, b));
                run_block(rexp, ~rdec, rdata, $sformatf("rnd k%0d b%0d inverse", k, b));
            end
        end

        // Reset during CRYPT round 15
        load_key(KEY_KAT, "pre-reset");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, PLAIN_KAT);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", 128'(out_valid), 128'd0);
        checkOutput("midrst key_loaded", 128'(key_loaded), 128'd0);
        checkOutput("midrst key_ready", 128'(key_ready), 128'd1);
        checkOutput("midrst in_ready", 128'(in_ready), 128'd0);
        checkOutput("midrst out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        load_key(KEY_KAT, "reload");
        checkOutput("reload rk0", 128'(dut.rkfile[0]), 128'h0F12186F9);
        run_block(PLAIN_KAT, 1'b0, CIPH_KAT, "reload enc");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
